// File: rtl/mux_rr_arbiter_pkg.sv
// Shared constants for the 4-way mux round-robin arbiter: sizes, FSM state codes
// and the grant decoder.
package mux_rr_arbiter_pkg;

  localparam int NUM_REQ     = 4;
  localparam int SEL_W       = 2;
  localparam int TIMEOUT_DEF = 16;
  localparam int CNT_W_DEF   = 8;

  localparam logic [1:0] ARB_IDLE = 2'b00;
  localparam logic [1:0] ARB_BUSY = 2'b01;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Requester/arbiter bundle: request and release inputs, grant and mux select outputs.
interface mux_rr_arbiter_if;
  import mux_rr_arbiter_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic               done;
  logic [NUM_REQ-1:0] grant;
  logic               grant_valid;
  logic [SEL_W-1:0]   select;
  logic               timeout;

  modport master (output req, done, input grant, grant_valid, select, timeout);
  modport slave  (input req, done, output grant, grant_valid, select, timeout);
endinterface

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Rotated priority search: first asserted request at ptr+1, ptr+2, ptr+3, then ptr.
// Purely combinational.
module rr_pick
  import mux_rr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  logic [SEL_W-1:0] cand;

  // Walk from lowest to highest priority so the last hit is the winner.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner of a shared 4:1 mux; registered one-hot grant plus binary select.
// Optional forced release after TIMEOUT busy cycles when MUX_ARB_TIMEOUT_EN is defined.
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  mux_rr_arbiter_if.slave  bus
);

  if (TIMEOUT < 2 || TIMEOUT > 255 || (1 << CNT_W) <= TIMEOUT) begin : g_bad_param
    $error("mux_rr_arbiter: TIMEOUT must be 2..255 and fit in CNT_W bits");
  end

  logic [1:0]         state;
  logic [NUM_REQ-1:0] grant_q;
  logic [SEL_W-1:0]   select_q;
  logic [SEL_W-1:0]   ptr;
  logic               found;
  logic [SEL_W-1:0]   pick_idx;
  logic               release_req;
  logic               force_rel;

  rr_pick u_pick (
    .req   (bus.req),
    .ptr   (ptr),
    .found (found),
    .idx   (pick_idx)
  );

  assign release_req     = bus.done | ~bus.req[select_q];
  assign bus.grant       = grant_q;
  assign bus.grant_valid = (state == ARB_BUSY);
  assign bus.select      = select_q;

`ifdef MUX_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt;
  logic             timeout_q;

  assign force_rel   = (cnt == CNT_W'(TIMEOUT - 1));
  assign bus.timeout = timeout_q;

  // A normal release on the expiry cycle takes precedence and suppresses the pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= (state == ARB_BUSY) && !release_req && force_rel;
      if (state == ARB_BUSY && !release_req && !force_rel)
        cnt <= cnt + 1'b1;
      else
        cnt <= '0;
    end
  end
`else
  assign force_rel   = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ARB_IDLE;
      grant_q  <= '0;
      select_q <= '0;
      ptr      <= SEL_W'(NUM_REQ - 1);
    end else begin
      case (state)
        ARB_IDLE: begin
          if (found) begin
            state    <= ARB_BUSY;
            grant_q  <= onehot(pick_idx);
            select_q <= pick_idx;
          end
        end
        ARB_BUSY: begin
          // Always drop to IDLE for a cycle, so grants are never back-to-back.
          if (release_req || force_rel) begin
            state   <= ARB_IDLE;
            grant_q <= '0;
            ptr     <= select_q;
          end
        end
        default: begin
          state   <= ARB_IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter with a per-cycle owner/pointer model.
module tb_mux_rr_arbiter;

  localparam int TMO = 4;
`ifdef MUX_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;
  bit   chk_en = 1'b0;

  mux_rr_arbiter_if bus ();

  mux_rr_arbiter #(.TIMEOUT(TMO), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Model: current owner (-1 when idle), last owner pointer, busy cycles held.
  int   m_owner, m_ptr, m_hold, m_sel;
  logic m_to;

  always @(posedge clk) begin : model
    int   nx_owner, nx_ptr, nx_hold, nx_sel;
    logic nx_to, hit;
    nx_owner = m_owner; nx_ptr = m_ptr; nx_hold = m_hold; nx_sel = m_sel;
    nx_to = 1'b0; hit = 1'b0;
    if (reset) begin
      nx_owner = -1; nx_ptr = 3; nx_hold = 0; nx_sel = 0;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= 4; k++)
        if (!hit && bus.req[(m_ptr + k) % 4]) begin
          hit = 1'b1;
          nx_owner = (m_ptr + k) % 4;
        end
      if (hit) begin nx_sel = nx_owner; nx_hold = 0; end
    end else if (bus.done || !bus.req[m_owner]) begin
      nx_owner = -1; nx_ptr = m_owner;
    end else if (TMO_EN && m_hold == TMO - 1) begin
      nx_owner = -1; nx_ptr = m_owner; nx_to = 1'b1;
    end else begin
      nx_hold = m_hold + 1;
    end
    m_owner <= nx_owner; m_ptr <= nx_ptr; m_hold <= nx_hold;
    m_sel <= nx_sel; m_to <= nx_to;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_grant", 32'(bus.grant), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
      chk("cyc_valid", 32'(bus.grant_valid), (m_owner < 0) ? 32'd0 : 32'd1);
      chk("cyc_select", 32'(bus.select), 32'(m_sel));
      chk("cyc_timeout", 32'(bus.timeout), 32'(m_to));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req = 4'b0000;
    bus.done = 1'b0;
    step();
    reset = 1'b0;
  endtask

  int ord[5] = '{0, 1, 2, 3, 0};
  int to_seen;

  initial begin
    reset = 1'b1;
    bus.req = 4'b0000;
    bus.done = 1'b0;
    step();
    chk_en = 1'b1;
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_valid", 32'(bus.grant_valid), 32'd0);
    chk("rst_select", 32'(bus.select), 32'd0);
    chk("rst_timeout", 32'(bus.timeout), 32'd0);
    chk("rst_model_ptr", 32'(m_ptr), 32'd3);
    reset = 1'b0;

    // Single request: one-cycle latency to grant.
    bus.req = 4'b0100;
    step();
    chk("t1_grant", 32'(bus.grant), 32'h4);
    chk("t1_select", 32'(bus.select), 32'd2);
    chk("t1_valid", 32'(bus.grant_valid), 32'd1);

    // All requesting, done pulsed per grant: order 0,1,2,3,0 with idle gaps.
    do_reset();
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_grant", 32'(bus.grant), 32'd1 << ord[i]);
      chk("t2_select", 32'(bus.select), 32'(ord[i]));
      bus.done = 1'b1;
      step();
      chk("t2_gap", 32'(bus.grant), 32'd0);
      bus.done = 1'b0;
    end

    // Owner drops its request: release, ptr=1, requester 2 beats requester 0.
    do_reset();
    bus.req = 4'b0010;
    step();
    chk("t3_grant1", 32'(bus.grant), 32'h2);
    bus.req = 4'b0101;
    step();
    chk("t3_release", 32'(bus.grant), 32'd0);
    chk("t3_model_ptr", 32'(m_ptr), 32'd1);
    step();
    chk("t3_grant2", 32'(bus.grant), 32'h4);
    chk("t3_select2", 32'(bus.select), 32'd2);

    // Reset in the middle of a grant, then 1001 goes to requester 0.
    do_reset();
    bus.req = 4'b1000;
    step();
    chk("t4_grant3", 32'(bus.grant), 32'h8);
    reset = 1'b1;
    step();
    chk("t4_rst_grant", 32'(bus.grant), 32'd0);
    chk("t4_rst_select", 32'(bus.select), 32'd0);
    chk("t4_rst_valid", 32'(bus.grant_valid), 32'd0);
    reset = 1'b0;
    bus.req = 4'b1001;
    step();
    chk("t4_grant0", 32'(bus.grant), 32'h1);

    // Requester 2 holds forever with done low.
    do_reset();
    bus.req = 4'b0100;
    step();
    chk("t5_grant", 32'(bus.grant), 32'h4);
    if (TMO_EN) begin
      for (int i = 2; i <= TMO; i++) begin
        step();
        chk("t5_held", 32'(bus.grant), 32'h4);
        chk("t5_no_pulse", 32'(bus.timeout), 32'd0);
      end
      step();
      chk("t5_forced", 32'(bus.grant), 32'd0);
      chk("t5_pulse", 32'(bus.timeout), 32'd1);
      step();
      chk("t5_pulse_end", 32'(bus.timeout), 32'd0);
      chk("t5_regrant", 32'(bus.grant), 32'h4);
    end else begin
      to_seen = 0;
      for (int i = 0; i < 55; i++) begin
        step();
        if (bus.timeout !== 1'b0) to_seen++;
      end
      chk("t5_held55", 32'(bus.grant), 32'h4);
      chk("t5_timeouts", 32'(to_seen), 32'd0);
    end

    // done while idle with no requests changes nothing.
    do_reset();
    bus.done = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("t6_grant", 32'(bus.grant), 32'd0);
    chk("t6_valid", 32'(bus.grant_valid), 32'd0);
    bus.done = 1'b0;
    step();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
